// File: rtl/blink_multi.sv
// Multi-channel LED blinker: shared prescaler tick, per-channel OFF/ON/BLINK/BURST modes.
// BURST support (burst/bcnt storage) is built only when BLINK_MULTI_BURST_EN is defined.
module blink_multi #(
    parameter int FREQ       = 25000000,
    parameter int TICK_HZ    = 1000,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_W   = 16,
    parameter int DEF_PERIOD = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_we_i,
    input  logic [3:0]          cfg_ch_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [PERIOD_W-1:0] cfg_duty_i,
    input  logic [3:0]          cfg_burst_i,
    input  logic                sync_i,
    output logic                tick_o,
    output logic [CHANNELS-1:0] led_o
);
    localparam int TICK_DIV = FREQ / TICK_HZ;
    localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(DEF_PERIOD);
    localparam logic [PERIOD_W-1:0] RST_DUTY   = PERIOD_W'(DEF_PERIOD / 2);
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic [CNT_W-1:0]    cnt_reg;
    logic [CHANNELS-1:0] level;

    // tick_o doubles as the internal tick that advances every channel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
            tick_o  <= 1'b0;
        end else begin
            tick_o  <= (cnt_reg == CNT_MAX);
            cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

`ifndef BLINK_MULTI_BURST_EN
    logic unused_burst;
    assign unused_burst = ^cfg_burst_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [1:0]          mode_reg;
            logic [PERIOD_W-1:0] period_reg;
            logic [PERIOD_W-1:0] duty_reg;
            logic [PERIOD_W-1:0] pcnt_reg;
            logic                sel;
            logic                clear;
            logic                wrap;
            logic                blink_lvl;
            logic                burst_ok;
            logic                lvl;

            assign sel       = cfg_we_i && (cfg_ch_i == 4'(gi));
            assign clear     = sel || sync_i;
            assign wrap      = (pcnt_reg == period_reg - PERIOD_W'(1));
            assign blink_lvl = (pcnt_reg < duty_reg);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mode_reg   <= MODE_OFF;
                    period_reg <= RST_PERIOD;
                    duty_reg   <= RST_DUTY;
                    pcnt_reg   <= '0;
                end else begin
                    if (sel) begin
                        mode_reg   <= cfg_mode_i;
                        period_reg <= (cfg_period_i == '0) ? PERIOD_W'(1) : cfg_period_i;
                        duty_reg   <= cfg_duty_i;
                    end
                    if (clear) begin
                        pcnt_reg <= '0;
                    end else if (tick_o) begin
                        pcnt_reg <= wrap ? '0 : pcnt_reg + PERIOD_W'(1);
                    end
                end
            end

`ifdef BLINK_MULTI_BURST_EN
            logic [3:0] burst_reg;
            logic [3:0] bcnt_reg;

            // bcnt counts completed periods; the period with bcnt == burst stays dark
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    burst_reg <= '0;
                    bcnt_reg  <= '0;
                end else begin
                    if (sel) begin
                        burst_reg <= cfg_burst_i;
                    end
                    if (clear) begin
                        bcnt_reg <= '0;
                    end else if (tick_o && wrap) begin
                        bcnt_reg <= (bcnt_reg == burst_reg) ? 4'd0 : bcnt_reg + 4'd1;
                    end
                end
            end

            assign burst_ok = (bcnt_reg < burst_reg);
`else
            assign burst_ok = 1'b1;
`endif

            always_comb begin
                lvl = 1'b0;
                case (mode_reg)
                    MODE_OFF:   lvl = 1'b0;
                    MODE_ON:    lvl = 1'b1;
                    MODE_BLINK: lvl = blink_lvl;
                    default:    lvl = burst_ok && blink_lvl;
                endcase
            end

            assign level[gi] = lvl;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= level;
        end
    end
endmodule

// File: doc/blink_multi.md
Name: blink_multi

Overview:
- Parametrised multi-channel LED blinker; successor to the single-channel fixed-period blinker.
- A shared prescaler generates a slow tick. Each channel has a runtime-configurable mode, period and duty, plus an optional burst mode.
- Sits between board-level LED pins and a simple register/config write port driven by a host or control FSM.

Parameters:
FREQ, 25000000, input clock frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; TICK_DIV = FREQ/TICK_HZ (integer, truncated, must be >= 2)
CHANNELS, 4, number of LED channels (1..16)
PERIOD_W, 16, width of period/duty fields, in ticks
DEF_PERIOD, 1000, reset period in ticks for every channel

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
cfg_we_i  in  1  config write strobe, one cycle
cfg_ch_i  in  4  target channel index
cfg_mode_i  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
cfg_period_i  in  PERIOD_W  period in ticks
cfg_duty_i  in  PERIOD_W  high time in ticks
cfg_burst_i  in  4  pulses per burst (BURST mode only)
sync_i  in  1  restart the phase of all channels
tick_o  out  1  one-cycle prescaler tick pulse
led_o  out  CHANNELS  LED outputs, active-high

Behaviour:
- Reset (async, any time): prescaler cnt = 0, tick_o = 0, led_o = 0.
- Reset values per channel: mode = OFF, period = DEF_PERIOD, duty = DEF_PERIOD/2, burst = 0, pcnt = 0, bcnt = 0.
- Prescaler: cnt counts 0..TICK_DIV-1 and wraps to 0. tick_o is registered and high for exactly one cycle, in the cycle after cnt == TICK_DIV-1. Free-running; not affected by sync_i or cfg writes.
- Config write: if cfg_we_i=1 and cfg_ch_i < CHANNELS, the channel's mode/period/duty/burst are loaded at that edge and its pcnt and bcnt are cleared. cfg_ch_i >= CHANNELS is ignored with no state change. A written period of 0 is stored as 1.
- sync_i=1: pcnt and bcnt of every channel are cleared at that edge; prescaler is untouched.
- If sync_i and cfg_we_i occur in the same cycle, both take effect; the written channel receives the new config with counters at 0.
- Phase counter: on each tick (internal tick, same cycle tick_o is asserted), pcnt = (pcnt == period-1) ? 0 : pcnt+1.
- Clear beats tick: a clear (write or sync) coincident with a tick leaves pcnt = 0.
- Channel level:
  - OFF -> 0.
  - ON -> 1.
  - BLINK -> (pcnt < duty). duty=0 gives constant 0; duty >= period gives constant 1.
  - BURST -> bcnt counts completed periods, 0..burst, wrapping to 0 after the period with bcnt == burst. Level = (bcnt < burst) && (pcnt < duty). The result is burst pulses followed by one dark period. burst=0 gives constant 0.
- led_o is registered from channel state: one cycle after the state update. A mode write is therefore visible on led_o on the second rising edge after the cfg_we_i edge.
- Widths: pcnt and duty are PERIOD_W bits; comparisons are unsigned; no overflow is possible because pcnt < period <= 2^PERIOD_W-1.
- Multiple writes in consecutive cycles are each applied in order; no back-pressure.

Optional Feature:
- Macro BLINK_MULTI_BURST_EN.
- Defined: BURST mode and bcnt counters exist exactly as described above.
- Undefined: no bcnt/burst storage is synthesised; cfg_burst_i is ignored; mode 11 behaves exactly as BLINK.

Test Plan:
Bench parameters for all scenarios: FREQ=100, TICK_HZ=10, so TICK_DIV=10.
1. Reset checks: assert rst_i mid-operation with BLINK running -> led_o=0 and tick_o=0 immediately (asynchronously). After release, tick_o pulses every 10 cycles with the first pulse 10 cycles after release.
2. BLINK timing: ch0 BLINK, period=4, duty=1 -> led_o[0] high 10 cycles, low 30 cycles, repeating. Edges are 1 cycle after the corresponding tick.
3. Duty boundaries: duty=0 -> led_o[ch] constant 0; duty=5 with period=4 -> constant 1. ch1 ON and ch2 OFF alongside -> 1 and 0 respectively.
4. Write handling: period=0 written -> stored as 1. A write with cfg_ch_i=CHANNELS -> no output or state change on any channel. A write to ch0 while ch1 is blinking -> ch1 phase is undisturbed.
5. sync_i alignment: two channels with the same period but offset phases -> after a sync_i pulse, their led_o edges coincide. sync_i with a simultaneous cfg write to ch0 -> ch0 takes the new config with phase 0.
6. BURST (macro defined): period=2, duty=1, burst=3 -> 3 pulses, then 2 dark ticks, repeating. Macro undefined: same write -> identical to BLINK (continuous pulses).
